// File: rtl/cordic_share_arbiter_pkg.sv
// Shared definitions for the CORDIC share arbiter.
// Holds pipeline latency, float width and the in-flight tag type.
package cordic_share_arbiter_pkg;

  localparam int CORDIC_LATENCY = 3;
  localparam int FLOAT_W        = 32;
  localparam int MAX_ID_W       = 3;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr wins.
// Ports: req, ptr in; one-hot grant, encoded idx and any out.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = W'(j);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/cordic_share_arbiter.sv
// Shares one pipelined CORDIC cosine unit among NUM_REQ requesters.
// Ports: clock/reset/clk_en, req_*, resp_*, in_flight, cordic_* side.
module cordic_share_arbiter
  import cordic_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = CORDIC_LATENCY,
  parameter int ID_W    = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [FLOAT_W-1:0]      resp_data,
  output logic [ID_W+1:0]         in_flight,
  output logic                    cordic_aclr,
  output logic                    cordic_clk_en,
  output logic [FLOAT_W-1:0]      cordic_dataa,
  input  logic [FLOAT_W-1:0]      cordic_result
);

  localparam int CW = ID_W + 2;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gidx;
  logic [ID_W-1:0]    next_ptr;
  logic [NUM_REQ-1:0] grant;
  logic               any;
  logic               accept;
  logic               done;
  tag_t               tags [LATENCY+1];

  rr_arbiter #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  assign req_ready     = grant & {NUM_REQ{clk_en & ~reset}};
  assign accept        = any & clk_en & ~reset;
  assign done          = tags[LATENCY].valid;
  assign cordic_aclr   = reset;
  assign cordic_clk_en = clk_en;

  assign next_ptr = (gidx == ID_W'(NUM_REQ - 1))
                  ? '0 : gidx + ID_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= LATENCY; i++) begin
        tags[i] <= '0;
      end
      ptr          <= '0;
      cordic_dataa <= '0;
      resp_valid   <= '0;
      resp_data    <= '0;
      in_flight    <= '0;
    end else if (clk_en) begin
      tags[0].valid <= accept;
      tags[0].id    <= MAX_ID_W'(gidx);
      for (int i = 1; i <= LATENCY; i++) begin
        tags[i] <= tags[i-1];
      end
      if (accept) begin
        cordic_dataa <= req_data[FLOAT_W*int'(gidx) +: FLOAT_W];
        ptr          <= next_ptr;
      end
      resp_data  <= cordic_result;
      resp_valid <= done
                  ? (NUM_REQ'(1) << tags[LATENCY].id)
                  : '0;
      case ({accept, done})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Bench for cordic_share_arbiter with a dataa+1 CORDIC stub.
// Scoreboard queue holds expected owner, data and due enabled edge.
module tb_cordic_share_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         clk_en = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   req_ready;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_data;
  logic [3:0]   in_flight;
  logic         cordic_aclr;
  logic         cordic_clk_en;
  logic [31:0]  cordic_dataa;
  logic [31:0]  cordic_result;

  logic [31:0]  s1, s2, s3;

  typedef struct {
    logic [3:0]  oh;
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   passed = 0;
  int   fails  = 0;
  int   total  = 0;
  int   ecnt   = 0;
  logic upd    = 1'b0;

  cordic_share_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .clk_en        (clk_en),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .in_flight     (in_flight),
    .cordic_aclr   (cordic_aclr),
    .cordic_clk_en (cordic_clk_en),
    .cordic_dataa  (cordic_dataa),
    .cordic_result (cordic_result)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (cordic_aclr) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else if (cordic_clk_en) begin
      s1 <= cordic_dataa + 32'd1;
      s2 <= s1;
      s3 <= s2;
    end
  end
  assign cordic_result = s3;

  always @(posedge clock) begin
    upd <= clk_en;
    if (clk_en && !reset) ecnt <= ecnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (upd) begin
      if (q.size() != 0 && q[0].due == ecnt) begin
        e = q.pop_front();
        chk("resp_valid", {28'b0, resp_valid}, {28'b0, e.oh});
        chk("resp_data", resp_data, e.d);
      end else begin
        chk("no_resp", {28'b0, resp_valid}, 32'h0);
      end
    end
  end

  task automatic cyc(input logic [3:0] v,
                     input logic       en,
                     input logic       rst,
                     input logic [3:0] rdy,
                     input int         exp_if);
    exp_t x;
    @(negedge clock);
    req_valid = v;
    clk_en    = en;
    reset     = rst;
    #1;
    if (rst) q.delete();
    chk("req_ready", {28'b0, req_ready}, {28'b0, rdy});
    chk("aclr", {31'b0, cordic_aclr}, {31'b0, rst});
    chk("cken", {31'b0, cordic_clk_en}, {31'b0, en});
    if (exp_if >= 0)
      chk("in_flight", {28'b0, in_flight}, 32'(exp_if));
    if (en && !rst && rdy != 4'b0) begin
      for (int i = 0; i < 4; i++) begin
        if (rdy[i]) begin
          x.oh  = rdy;
          x.d   = req_data[32*i +: 32] + 32'd1;
          x.due = ecnt + 5;
          q.push_back(x);
        end
      end
    end
  endtask

  initial begin
    // reset state
    cyc(4'b1111, 1'b1, 1'b1, 4'b0000, -1);
    cyc(4'b1111, 1'b1, 1'b1, 4'b0000, -1);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 0);
    chk("dataa_rst", cordic_dataa, 32'h0);

    // single request from requester 2
    req_data[95:64] = 32'h3F80_0000;
    cyc(4'b0100, 1'b1, 1'b0, 4'b0100, 0);
    for (int k = 0; k < 6; k++)
      cyc(4'b0000, 1'b1, 1'b0, 4'b0000, (k < 4) ? 1 : 0);

    // all four valid after reset: 0,1,2,3,0,1
    cyc(4'b0000, 1'b1, 1'b1, 4'b0000, -1);
    for (int i = 0; i < 4; i++)
      req_data[32*i +: 32] = 32'h10 * (i + 1);
    for (int i = 0; i < 6; i++)
      cyc(4'b1111, 1'b1, 1'b0, 4'(1 << (i % 4)), (i < 4) ? i : 4);
    for (int j = 0; j < 6; j++)
      cyc(4'b0000, 1'b1, 1'b0, 4'b0000, (j < 4) ? 4 - j : 0);

    // stall with two ops in flight, pointer at 2
    cyc(4'b0011, 1'b1, 1'b0, 4'b0001, 0);
    cyc(4'b0011, 1'b1, 1'b0, 4'b0010, 1);
    for (int k = 0; k < 3; k++)
      cyc(4'b1111, 1'b0, 1'b0, 4'b0000, 2);
    for (int k = 0; k < 6; k++)
      cyc(4'b0000, 1'b1, 1'b0, 4'b0000, (k == 5) ? 0 : -1);

    // reset flush after three accepts, pointer at 2
    cyc(4'b1111, 1'b1, 1'b0, 4'b0100, 0);
    cyc(4'b1111, 1'b1, 1'b0, 4'b1000, 1);
    cyc(4'b1111, 1'b1, 1'b0, 4'b0001, 2);
    cyc(4'b0000, 1'b1, 1'b1, 4'b0000, 3);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 0);
    chk("dataa_flush", cordic_dataa, 32'h0);
    chk("resp_flush", {28'b0, resp_valid}, 32'h0);
    cyc(4'b1111, 1'b1, 1'b0, 4'b0001, 0);

    // sparse requesters 1 and 3, NaN operand passes through
    req_data[63:32] = 32'h7FC0_0000;
    cyc(4'b0010, 1'b1, 1'b0, 4'b0010, 1);
    cyc(4'b1010, 1'b1, 1'b0, 4'b1000, 2);
    cyc(4'b1010, 1'b1, 1'b0, 4'b0010, 3);
    cyc(4'b1010, 1'b1, 1'b0, 4'b1000, 4);
    cyc(4'b1010, 1'b1, 1'b0, 4'b0010, 4);
    for (int k = 0; k < 7; k++)
      cyc(4'b0000, 1'b1, 1'b0, 4'b0000, (k == 6) ? 0 : -1);

    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
